// File: rtl/capture_pkg.sv
// Shared edge selectors and elaboration-time helpers for the capture bank.
package capture_pkg;

  typedef enum logic [0:0] {
    EDGE_FALL = 1'b0,
    EDGE_RISE = 1'b1
  } edge_e;

  // Bits needed to hold values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 1;
    r = 0;
    while (v != 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Largest value representable by an unsigned counter of the given width.
  function automatic int unsigned cnt_max(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/dff_bank.sv
// WIDTH-bit enabled register with asynchronous active-high reset; the EDGE
// parameter selects whether it captures on the rising or falling clock edge.
module dff_bank
  import capture_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter edge_e       EDGE  = EDGE_RISE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (EDGE == EDGE_RISE) begin : g_rise
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if (en) begin
        q <= d;
      end
    end
  end else begin : g_fall
    always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if (en) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/capture_bank.sv
// Captures a bus by level latch, rising and falling edge, keeps a rising-edge
// history and counts rising edges where the two edge captures disagree.
// CAPTURE_CNT_SAT_EN: when defined the mismatch counter saturates, else it wraps.
module capture_bank
  import capture_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q_lat,
  output logic [WIDTH-1:0] q_pos,
  output logic [WIDTH-1:0] q_neg,
  output logic [WIDTH-1:0] q_hist,
  output logic             hist_valid,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam int unsigned       FILL_W    = clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
`ifdef CAPTURE_CNT_SAT_EN
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(cnt_max(CNT_W));
`endif

  logic [WIDTH-1:0]  stage [DEPTH];
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              differ;

  // Level latch: open while clk is high and capture is enabled.
  always_latch begin
    if (rst) begin
      q_lat = '0;
    end else if (clk && en) begin
      q_lat = d;
    end
  end

  dff_bank #(
    .WIDTH (WIDTH),
    .EDGE  (EDGE_RISE)
  ) u_pos (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (d),
    .q   (q_pos)
  );

  dff_bank #(
    .WIDTH (WIDTH),
    .EDGE  (EDGE_FALL)
  ) u_neg (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (d),
    .q   (q_neg)
  );

  // History shift chain; stage 0 takes the live bus.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hist
    logic [WIDTH-1:0] stage_d;
    if (i == 0) begin : g_head
      assign stage_d = d;
    end else begin : g_tail
      assign stage_d = stage[i-1];
    end

    dff_bank #(
      .WIDTH (WIDTH),
      .EDGE  (EDGE_RISE)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (stage_d),
      .q   (stage[i])
    );
  end

  assign q_hist = stage[DEPTH-1];
  assign differ = (q_pos != q_neg);

  // Fill level: clear wins, otherwise count enabled edges up to DEPTH.
  always_comb begin
    fill_nxt = fill;
    if (clr) begin
      fill_nxt = '0;
    end else if (en && (fill != FILL_FULL)) begin
      fill_nxt = fill + FILL_W'(1);
    end
  end

  always_comb begin
    cnt_nxt = mismatch_cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (differ) begin
`ifdef CAPTURE_CNT_SAT_EN
      if (mismatch_cnt != CNT_MAX) begin
        cnt_nxt = mismatch_cnt + CNT_W'(1);
      end
`else
      cnt_nxt = mismatch_cnt + CNT_W'(1);
`endif
    end
  end

  // Mismatch evaluation runs every rising edge regardless of enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill         <= '0;
      hist_valid   <= 1'b0;
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      fill         <= fill_nxt;
      hist_valid   <= (fill_nxt == FILL_FULL);
      mismatch     <= differ;
      mismatch_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_capture_bank.sv
// Self-checking bench for capture_bank: a behavioural model pushes the expected
// rising-edge outputs into a queue, and each scenario pops and compares them.
module tb_capture_bank;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [7:0] pos;
    logic [7:0] hist;
    logic       valid;
    logic       mis;
    logic [1:0] cnt;
  } snap_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] d;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] q_lat;
  logic [WIDTH-1:0] q_pos;
  logic [WIDTH-1:0] q_neg;
  logic [WIDTH-1:0] q_hist;
  logic             hist_valid;
  logic             mismatch;
  logic [CNT_W-1:0] mismatch_cnt;

  int    tests_run    = 0;
  int    tests_failed = 0;
  snap_t want_q [$];
  snap_t want;
  snap_t obs;

  logic [7:0]  m_pos;
  logic [7:0]  m_neg;
  logic [7:0]  m_lat;
  logic [7:0]  m_hist [DEPTH];
  int unsigned m_fill;
  logic        m_mis;
  logic [1:0]  m_cnt;

  capture_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .d            (d),
    .en           (en),
    .clr          (clr),
    .q_lat        (q_lat),
    .q_pos        (q_pos),
    .q_neg        (q_neg),
    .q_hist       (q_hist),
    .hist_valid   (hist_valid),
    .mismatch     (mismatch),
    .mismatch_cnt (mismatch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [1:0] cnt_step(input logic [1:0] c);
`ifdef CAPTURE_CNT_SAT_EN
    return (c == 2'd3) ? c : c + 2'd1;
`else
    return c + 2'd1;
`endif
  endfunction

  // Reference model: the expected post-edge outputs are queued at each rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos  <= '0;
      for (int i = 0; i < DEPTH; i++) m_hist[i] <= '0;
      m_fill <= 0;
      m_mis  <= 1'b0;
      m_cnt  <= '0;
      want_q.delete();
    end else begin
      want_q.push_back('{pos:   en ? d : m_pos,
                         hist:  en ? m_hist[DEPTH-2] : m_hist[DEPTH-1],
                         valid: !clr && ((m_fill == DEPTH) || (en && (m_fill == DEPTH - 1))),
                         mis:   (m_pos != m_neg),
                         cnt:   clr ? 2'd0 : ((m_pos != m_neg) ? cnt_step(m_cnt) : m_cnt)});
      m_mis <= (m_pos != m_neg);
      m_cnt <= clr ? 2'd0 : ((m_pos != m_neg) ? cnt_step(m_cnt) : m_cnt);
      if (en) begin
        m_pos     <= d;
        m_hist[0] <= d;
        for (int i = 1; i < DEPTH; i++) m_hist[i] <= m_hist[i-1];
      end
      if (clr) m_fill <= 0;
      else if (en && (m_fill < DEPTH)) m_fill <= m_fill + 1;
    end
  end

  always @(negedge clk or posedge rst) begin
    if (rst) m_neg <= '0;
    else if (en) m_neg <= d;
  end

  always @(clk or en or d or rst) begin
    if (rst) m_lat = '0;
    else if (clk && en) m_lat = d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (want_q.size() != 0) want = want_q.pop_front();
    obs = '{pos: q_pos, hist: q_hist, valid: hist_valid, mis: mismatch, cnt: mismatch_cnt};
  endtask

  task automatic test_reset();
    tests_run++;
    if ({q_lat, q_pos, q_neg, q_hist, hist_valid, mismatch, mismatch_cnt} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h want 0",
               {q_lat, q_pos, q_neg, q_hist, hist_valid, mismatch, mismatch_cnt});
    end
    en = 1'b1;
    d  = 8'hA5;
    tick();
    tests_run++;
    if (obs !== want) begin
      tests_failed++;
      $display("FAIL reset_pre_rise: got %h want %h", obs, want);
    end
    tests_run++;
    if (q_lat !== 8'hA5) begin
      tests_failed++;
      $display("FAIL reset_pre_lat: got %h want a5", q_lat);
    end
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({q_lat, q_pos, q_neg, q_hist, hist_valid, mismatch, mismatch_cnt} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_async_high: got %h want 0",
               {q_lat, q_pos, q_neg, q_hist, hist_valid, mismatch, mismatch_cnt});
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({q_lat, q_pos, q_neg, q_hist, hist_valid, mismatch, mismatch_cnt} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_hold_low: got %h want 0",
               {q_lat, q_pos, q_neg, q_hist, hist_valid, mismatch, mismatch_cnt});
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({q_lat, q_pos, q_neg, q_hist, hist_valid, mismatch, mismatch_cnt} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_hold_high: got %h want 0",
               {q_lat, q_pos, q_neg, q_hist, hist_valid, mismatch, mismatch_cnt});
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    d   = 8'h3C;
    #1;
    tests_run++;
    if ({q_lat, q_pos, q_neg, q_hist, hist_valid, mismatch, mismatch_cnt} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_release: got %h want 0",
               {q_lat, q_pos, q_neg, q_hist, hist_valid, mismatch, mismatch_cnt});
    end
  endtask

  task automatic test_capture();
    tick();
    tests_run++;
    if (obs !== want) begin
      tests_failed++;
      $display("FAIL capture_rise1: got %h want %h", obs, want);
    end
    tests_run++;
    if (q_pos !== 8'h3C) begin
      tests_failed++;
      $display("FAIL capture_q_pos: got %h want 3c", q_pos);
    end
    tests_run++;
    if (q_lat !== 8'h3C) begin
      tests_failed++;
      $display("FAIL capture_lat_open: got %h want 3c", q_lat);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (q_neg !== 8'h3C) begin
      tests_failed++;
      $display("FAIL capture_q_neg: got %h want 3c", q_neg);
    end
    tests_run++;
    if (q_lat !== 8'h3C) begin
      tests_failed++;
      $display("FAIL capture_lat_hold: got %h want 3c", q_lat);
    end
    tick();
    tests_run++;
    if (obs !== want) begin
      tests_failed++;
      $display("FAIL capture_rise2: got %h want %h", obs, want);
    end
    tests_run++;
    if (mismatch_cnt !== 2'd0) begin
      tests_failed++;
      $display("FAIL capture_cnt: got %0d want 0", mismatch_cnt);
    end
  endtask

  task automatic test_history();
    logic vexp;
    @(negedge clk);
    #1;
    en  = 1'b0;
    clr = 1'b1;
    tick();
    tests_run++;
    if (obs !== want) begin
      tests_failed++;
      $display("FAIL hist_clr: got %h want %h", obs, want);
    end
    tests_run++;
    if (hist_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hist_clr_valid: got %b want 0", hist_valid);
    end
    @(negedge clk);
    #1;
    en  = 1'b1;
    clr = 1'b0;
    d   = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      tick();
      vexp = (k >= 4);
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("FAIL hist_rise%0d: got %h want %h", k, obs, want);
      end
      tests_run++;
      if (hist_valid !== vexp) begin
        tests_failed++;
        $display("FAIL hist_valid_rise%0d: got %b want %b", k, hist_valid, vexp);
      end
      if (k >= 4) begin
        tests_run++;
        if (q_hist !== 8'(k - 3)) begin
          tests_failed++;
          $display("FAIL hist_q_rise%0d: got %h want %h", k, q_hist, 8'(k - 3));
        end
      end
      if (k < 5) begin
        @(negedge clk);
        #1;
        d = 8'(k + 1);
      end
    end
  endtask

  task automatic test_mismatch();
    for (int i = 0; i < 4; i++) begin
      d = 8'h40 + 8'(i);
      tick();
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("FAIL mismatch_rise%0d: got %h want %h", i, obs, want);
      end
      tests_run++;
      if (mismatch !== 1'b1) begin
        tests_failed++;
        $display("FAIL mismatch_flag%0d: got %b want 1", i, mismatch);
      end
    end
  endtask

  task automatic test_cnt_end();
    logic [1:0] want_cnt [5];
`ifdef CAPTURE_CNT_SAT_EN
    want_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
    want_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif
    @(negedge clk);
    #1;
    en  = 1'b1;
    clr = 1'b1;
    d   = 8'h11;
    tick();
    tests_run++;
    if (mismatch_cnt !== 2'd0) begin
      tests_failed++;
      $display("FAIL cntend_clr: got %0d want 0", mismatch_cnt);
    end
    @(negedge clk);
    #1;
    clr = 1'b0;
    tick();
    tests_run++;
    if ({mismatch, mismatch_cnt} !== 3'b000) begin
      tests_failed++;
      $display("FAIL cntend_equal: got %b want 000", {mismatch, mismatch_cnt});
    end
    for (int i = 0; i < 5; i++) begin
      d = 8'h20 + 8'(i);
      tick();
      tests_run++;
      if (mismatch_cnt !== want_cnt[i]) begin
        tests_failed++;
        $display("FAIL cntend_cnt%0d: got %0d want %0d", i, mismatch_cnt, want_cnt[i]);
      end
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("FAIL cntend_rise%0d: got %h want %h", i, obs, want);
      end
    end
    d = 8'h25;
    @(negedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic test_enable();
    for (int i = 0; i < 3; i++) begin
      d = 8'hF0 ^ 8'(i);
      tick();
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("FAIL enable_rise%0d: got %h want %h", i, obs, want);
      end
      tests_run++;
      if ({q_pos, q_lat, mismatch} !== {8'h24, 8'h25, 1'b1}) begin
        tests_failed++;
        $display("FAIL enable_frozen%0d: got %h want %h", i, {q_pos, q_lat, mismatch},
                 {8'h24, 8'h25, 1'b1});
      end
      d = 8'h0F ^ 8'(i);
      @(negedge clk);
      #1;
      tests_run++;
      if ({q_neg, q_lat} !== {8'h25, m_lat}) begin
        tests_failed++;
        $display("FAIL enable_neg%0d: got %h want %h", i, {q_neg, q_lat}, {8'h25, m_lat});
      end
    end
    clr = 1'b1;
    tick();
    tests_run++;
    if ({mismatch_cnt, mismatch, hist_valid} !== 4'b0010) begin
      tests_failed++;
      $display("FAIL enable_clr: got %b want 0010", {mismatch_cnt, mismatch, hist_valid});
    end
    tests_run++;
    if (obs !== want) begin
      tests_failed++;
      $display("FAIL enable_clr_snap: got %h want %h", obs, want);
    end
    clr = 1'b0;
    tick();
    tests_run++;
    if ({mismatch_cnt, mismatch} !== 3'b011) begin
      tests_failed++;
      $display("FAIL enable_after_clr: got %b want 011", {mismatch_cnt, mismatch});
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    d   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    test_reset();
    test_capture();
    test_history();
    test_mismatch();
    test_cnt_end();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
